// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy flags and sticky error flags.
// FWFT selects between a registered read port and a first-word-fall-through read port.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_ok, wr_ok;

  // Handshake: a read is taken when rd_en is high and the FIFO holds a word;
  // a write is taken when wr_en is high and there is room, where a same-cycle
  // accepted read frees the slot. Rejected requests only set the sticky flags.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_ok && !rd_ok) count_d = count_q + CW'(1);
    if (rd_ok && !wr_ok) count_d = count_q - CW'(1);
    // Setting wins over clearing so an error in the clear cycle is not lost.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && full && !rd_ok) overflow_d  = 1'b1;
    if (rd_en && empty)          underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
      assign rd_valid = !empty;
    end else begin : g_std
      logic [DATA_W-1:0] rd_data_q, rd_data_d;
      logic              rd_valid_q, rd_valid_d;

      // At full with a same-cycle write, this reads the old word before it is replaced.
      always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_ok;
        if (rd_ok) rd_data_d = mem_q[rd_ptr_q];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-mode and an FWFT instance share inputs
// and are checked against a queue-based model of the FIFO.
module tb_sync_fifo_param;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = 3;
  localparam int AE_LEVEL = 1;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic              clr_err;

  logic [DATA_W-1:0] s_rd_data, f_rd_data;
  logic              s_rd_valid, f_rd_valid;
  logic              s_full, f_full, s_empty, f_empty;
  logic              s_af, f_af, s_ae, f_ae;
  logic [CW-1:0]     s_count, f_count;
  logic              s_ovf, f_ovf, s_unf, f_unf;

  logic [DATA_W-1:0] exp_q[$];
  logic              exp_ovf, exp_unf, exp_sv;
  logic [DATA_W-1:0] exp_sd;
  int                errors = 0;
  int                checks = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL),
                    .AE_LEVEL(AE_LEVEL), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err)
  );

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL),
                    .AE_LEVEL(AE_LEVEL), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    int n;
    logic [DATA_W-1:0] head;
    n = exp_q.size();
    head = (n > 0) ? exp_q[0] : '0;
    chk({ph, ":s_count"},  32'(s_count),  32'(n));
    chk({ph, ":s_full"},   32'(s_full),   32'(n == DEPTH));
    chk({ph, ":s_empty"},  32'(s_empty),  32'(n == 0));
    chk({ph, ":s_af"},     32'(s_af),     32'(n >= AF_LEVEL));
    chk({ph, ":s_ae"},     32'(s_ae),     32'(n <= AE_LEVEL));
    chk({ph, ":s_ovf"},    32'(s_ovf),    32'(exp_ovf));
    chk({ph, ":s_unf"},    32'(s_unf),    32'(exp_unf));
    chk({ph, ":s_valid"},  32'(s_rd_valid), 32'(exp_sv));
    chk({ph, ":s_data"},   32'(s_rd_data),  32'(exp_sd));
    chk({ph, ":f_count"},  32'(f_count),  32'(n));
    chk({ph, ":f_flags"},  {28'd0, f_full, f_empty, f_af, f_ae},
        {28'd0, n == DEPTH, n == 0, n >= AF_LEVEL, n <= AE_LEVEL});
    chk({ph, ":f_err"},    {30'd0, f_ovf, f_unf}, {30'd0, exp_ovf, exp_unf});
    chk({ph, ":f_valid"},  32'(f_rd_valid), 32'(n > 0));
    chk({ph, ":f_data"},   32'(f_rd_data),  32'(head));
  endtask

  task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r,
                      input logic c);
    int   n;
    logic rd_ok, wr_ok;
    wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    @(posedge clk);
    n     = exp_q.size();
    rd_ok = r && (n > 0);
    wr_ok = w && ((n < DEPTH) || rd_ok);
    if (w && (n == DEPTH) && !rd_ok) exp_ovf = 1'b1;
    else if (c)                      exp_ovf = 1'b0;
    if (r && (n == 0)) exp_unf = 1'b1;
    else if (c)        exp_unf = 1'b0;
    exp_sv = rd_ok;
    if (rd_ok) exp_sd = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(d);
    #1;
    check_all("step");
  endtask

  task automatic reset_dut(input logic w);
    rst = 1'b1; wr_en = w; wr_data = 8'hEE; rd_en = 1'b0; clr_err = 1'b0;
    @(posedge clk);
    exp_q.delete();
    exp_ovf = 1'b0; exp_unf = 1'b0; exp_sv = 1'b0; exp_sd = '0;
    #1;
    rst = 1'b0; wr_en = 1'b0;
    check_all("reset");
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; clr_err = 1'b0;
    exp_ovf = 1'b0; exp_unf = 1'b0; exp_sv = 1'b0; exp_sd = '0;

    reset_dut(1'b0);
    chk("reset_empty", 32'(s_empty), 32'd1);

    // Fill to full
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    chk("af_at_3", 32'(s_af), 32'd1);
    step(1, 8'h44, 0, 0);
    chk("full_after_4", {31'd0, s_full}, 32'd1);

    // Rejected write, then drain
    step(1, 8'h55, 0, 0);
    chk("ovf_set", 32'(s_ovf), 32'd1);
    chk("ovf_count", 32'(s_count), 32'd4);
    step(0, 8'h00, 1, 0);
    chk("pop_first", 32'(s_rd_data), 32'h11);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    chk("pop_last", 32'(s_rd_data), 32'h44);
    step(0, 8'h00, 0, 1);

    // Full with simultaneous read/write, across pointer wrap
    for (int i = 0; i < 4; i++) step(1, 8'(i + 1), 0, 0);
    for (int i = 0; i < 6; i++) step(1, 8'hA0 + 8'(i), 1, 0);
    chk("wrap_old_word", 32'(s_rd_data), 32'hA1);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
    chk("wrap_drained", 32'(s_rd_data), 32'hA5);

    // Underflow and clear priority
    step(0, 8'h00, 1, 0);
    chk("unf_set", 32'(s_unf), 32'd1);
    step(0, 8'h00, 1, 1);
    chk("unf_set_wins", 32'(s_unf), 32'd1);
    step(0, 8'h00, 0, 1);
    chk("unf_cleared", 32'(s_unf), 32'd0);

    // FWFT presentation
    step(1, 8'h5A, 0, 0);
    chk("fwft_present", 32'(f_rd_data), 32'h5A);
    step(0, 8'h00, 1, 0);
    chk("fwft_empty", 32'(f_rd_valid), 32'd0);
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 1, 0);
    chk("fwft_next", 32'(f_rd_data), 32'h02);
    step(0, 8'h00, 1, 0);

    // Reset mid-stream with a pending write
    step(1, 8'h61, 0, 0);
    step(1, 8'h62, 0, 0);
    step(1, 8'h63, 0, 0);
    reset_dut(1'b1);
    chk("rst_no_store", 32'(s_count), 32'd0);

    // Random traffic, alternating write-heavy and read-heavy phases
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = ((i / 40) % 2 == 0) ? 75 : 25;
      if ($urandom_range(0, 59) == 0) begin
        reset_dut(1'($urandom_range(0, 1)));
      end else begin
        step(($urandom_range(0, 99) < wp), 8'($urandom), ($urandom_range(0, 99) >= wp),
             ($urandom_range(0, 15) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO with a single clock domain, configurable data width and depth. Provides full, empty, almost-full and almost-empty flags, an occupancy count, and sticky overflow/underflow error flags. Supports simultaneous read and write in the same cycle. Supports two read modes: standard (registered read data) and first-word-fall-through. Used as the general-purpose buffer between streaming blocks, replacing fixed 4x8 FIFOs.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard read mode; 1 = first-word-fall-through mode

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
wr_en  in  1  write request
wr_data  in  DATA_W  write data
rd_en  in  1  read/pop request
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data holds a valid popped word (standard) / head word present (FWFT)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected
clr_err  in  1  clears overflow/underflow

Behaviour:
- Reset (rst=1 at a clk edge): write/read pointers=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. This gives empty=1, full=0, almost_full=0, almost_empty=1. Memory contents are not reset. Reset overrides all other inputs in the same cycle, including mid-stream; all queued data is discarded.
- Read accept: rd_ok = rd_en && !empty.
- Write accept: wr_ok = wr_en && (!full || rd_ok).
  - A write while full is accepted only when a read is accepted in the same cycle.
  - A write while empty is always accepted.
- Write: on wr_ok, mem[wr_ptr] <= wr_data; wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Read: on rd_ok, rd_ptr increments modulo DEPTH.
- Count update:
  - +1 on wr_ok && !rd_ok
  - -1 on rd_ok && !wr_ok
  - unchanged when both or neither are accepted
  - count never exceeds DEPTH and never goes below 0
- Flags: combinational from the registered count. They reflect the state after the most recent edge, with no extra lag.
- Standard mode (FWFT=0):
  - On rd_ok, rd_data <= mem[rd_ptr] and rd_valid <= 1 at the same edge. Latency is 1 cycle from rd_en sampled to data.
  - When there is no rd_ok, rd_valid <= 0 and rd_data holds its last value.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] combinationally; rd_valid = !empty.
  - rd_en acts as pop/acknowledge of the presented word.
  - A word written into an empty FIFO appears on rd_data in the cycle after the write edge.
  - rd_data is don't-care when rd_valid=0, but the reset value is 0 (drive 0 when empty).
- Read/write hazard: a same-cycle read and write at the same address cannot occur except when count is 0 or DEPTH. At count 0 the read is rejected; at count DEPTH the read returns the old word at rd_ptr before the write lands.
- Error flags:
  - overflow <= 1 on wr_en && full && !rd_ok.
  - underflow <= 1 on rd_en && empty.
  - Both hold until rst or clr_err. Set has priority over clr_err in the same cycle.
  - Rejected operations change no pointer, count or memory.

Test Plan:
- DEPTH=4, FWFT=0: reset, write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; full=1 after the 4th edge; almost_full follows AF_LEVEL=3 (asserts at count 3).
- Same setup, 5th write 0x55 with rd_en=0 -> write rejected, overflow=1, count stays 4. Then read 4 times -> rd_data 0x11,0x22,0x33,0x44 each one cycle after rd_en, with rd_valid=1; then empty=1.
- Full FIFO, wr_en=rd_en=1 with 0xAA -> read returns the oldest word, write accepted, count stays 4. Repeat 6 cycles to exercise pointer wrap; output order is preserved.
- Empty FIFO, rd_en=1 -> underflow=1, rd_valid=0, count 0. With clr_err=1 and rd_en=1 in the same cycle -> underflow stays 1. clr_err alone -> underflow clears.
- FWFT=1, DEPTH=4: write 0x5A into empty -> next cycle rd_valid=1, rd_data=0x5A with no rd_en. Pop -> rd_valid=0, empty=1. Simultaneous write+pop at count 1 -> count stays 1 and the new word is presented next.
- Assert rst mid-stream at count 3 with wr_en=1 -> next cycle count=0, empty=1, rd_valid=0, rd_data=0, errors 0. The write is not stored.
